// File: rtl/qr_row_skew_feeder_if.sv
// rtl/qr_row_skew_feeder_if.sv - row handshake bundle between the row source and the skew feeder
interface qr_row_skew_feeder_if #(
  parameter int N      = 4,
  parameter int DATA_W = 16
);
  logic [N-1:0][DATA_W-1:0] in_x;
  logic                     in_valid;
  logic                     in_last;
  logic                     in_ready;

  modport master (output in_x, output in_valid, output in_last, input in_ready);
  modport slave  (input in_x, input in_valid, input in_last, output in_ready);
endinterface

// File: rtl/qr_row_skew_feeder.sv
// rtl/qr_row_skew_feeder.sv - diagonal row skew, freeze and block tracking for the QR systolic array
// Optional row counter output rows_seen enabled by FEEDER_ROWCNT_EN.
module qr_row_skew_feeder #(
  parameter int N      = 4,
  parameter int DATA_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  qr_row_skew_feeder_if.slave      row,
  input  logic                     stall,
  output logic [N-1:0][DATA_W-1:0] col_x,
  output logic [N-1:0]             col_freeze,
  output logic                     done
`ifdef FEEDER_ROWCNT_EN
  ,
  output logic [CNT_W-1:0]         rows_seen
`endif
);

  localparam int DCW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;

  state_t         state, state_nxt;
  logic [DCW-1:0] dcnt, dcnt_nxt;
  logic           accept;

  assign row.in_ready = rst_n && !stall && (state != DRAIN);
  assign accept       = row.in_valid && row.in_ready;

  // Column j: j delay stages plus the output register, i.e. j+1 stages total.
  for (genvar j = 0; j < N; j++) begin : g_col
    logic [DATA_W-1:0] sx [0:j];
    logic              sv [0:j];

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        for (int k = 0; k <= j; k++) begin
          sx[k] <= '0;
          sv[k] <= 1'b0;
        end
      end else if (!stall) begin
        sx[0] <= accept ? row.in_x[j] : '0;
        sv[0] <= accept;
        for (int k = 1; k <= j; k++) begin
          sx[k] <= sx[k-1];
          sv[k] <= sv[k-1];
        end
      end
    end

    assign col_x[j]      = sv[j] ? sx[j] : '0;
    assign col_freeze[j] = stall || !sv[j];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      dcnt  <= '0;
    end else begin
      state <= state_nxt;
      dcnt  <= dcnt_nxt;
    end
  end

  // Drain count covers the extra cycles until the last row's top-right element lands.
  always_comb begin
    state_nxt = state;
    dcnt_nxt  = dcnt;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = row.in_last ? DRAIN : STREAM;
          if (row.in_last) dcnt_nxt = DCW'(N - 1);
        end
      end
      STREAM: begin
        if (accept && row.in_last) begin
          state_nxt = DRAIN;
          dcnt_nxt  = DCW'(N - 1);
        end
      end
      DRAIN: begin
        if (!stall) begin
          if (dcnt == '0) begin
            done      = rst_n;
            state_nxt = IDLE;
          end else begin
            dcnt_nxt = dcnt - DCW'(1);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef FEEDER_ROWCNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rows_seen <= '0;
    end else if (accept) begin
      if (state == IDLE)
        rows_seen <= CNT_W'(1);
      else if (rows_seen != {CNT_W{1'b1}})
        rows_seen <= rows_seen + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_qr_row_skew_feeder.sv
// tb/tb_qr_row_skew_feeder.sv - scoreboard bench for qr_row_skew_feeder
module tb_qr_row_skew_feeder;
  localparam int N      = 4;
  localparam int DATA_W = 16;
  localparam int CNT_W  = 16;
  localparam longint MAXR = (64'd1 << CNT_W) - 1;

  typedef logic [N-1:0][DATA_W-1:0] row_t;
  typedef struct {
    logic [DATA_W-1:0] x;
    int                due;
  } item_t;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic                     stall;
  logic [N-1:0][DATA_W-1:0] col_x;
  logic [N-1:0]             col_freeze;
  logic                     done;
`ifdef FEEDER_ROWCNT_EN
  logic [CNT_W-1:0]         rows_seen;
`endif

  always #5 clk = ~clk;

  qr_row_skew_feeder_if #(.N(N), .DATA_W(DATA_W)) row ();

  qr_row_skew_feeder #(.N(N), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .row        (row),
    .stall      (stall),
    .col_x      (col_x),
    .col_freeze (col_freeze),
    .done       (done)
`ifdef FEEDER_ROWCNT_EN
    ,
    .rows_seen  (rows_seen)
`endif
  );

  int     checks = 0;
  int     errors = 0;
  item_t  colq [N][$];
  int     adv = 0;
  bit     drain_pending = 1'b0;
  int     done_due = 0;
  longint exp_rows = 0;
  bit     in_block = 1'b0;

  task automatic check(input string name, input int col, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s col %0d got %0h exp %0h at %0t", name, col, got, exp, $time);
    end
  endtask

  // Reference: each accepted element is due on column j after j+1 unstalled edges.
  always @(negedge clk) begin : monitor
    bit acc;
    bit exp_done;
    bit vis;
    if (!rst_n) begin
      check("in_ready_rst", 0, row.in_ready, 0);
      check("done_rst", 0, done, 0);
      for (int j = 0; j < N; j++) colq[j].delete();
      drain_pending = 1'b0;
      exp_rows      = 0;
      in_block      = 1'b0;
    end else begin
      acc      = row.in_valid && !stall && !drain_pending;
      exp_done = drain_pending && (adv == done_due) && !stall;
      check("in_ready", 0, row.in_ready, !stall && !drain_pending);
      check("done", 0, done, exp_done);
      for (int j = 0; j < N; j++) begin
        vis = (colq[j].size() > 0) && (colq[j][0].due == adv);
        check("col_freeze", j, col_freeze[j], stall ? 1'b1 : !vis);
        check("col_x", j, col_x[j], vis ? colq[j][0].x : '0);
        if (vis && !stall) void'(colq[j].pop_front());
      end
`ifdef FEEDER_ROWCNT_EN
      check("rows_seen", 0, rows_seen, exp_rows);
`endif
      if (exp_done) drain_pending = 1'b0;
      if (acc) begin
        for (int j = 0; j < N; j++) colq[j].push_back('{row.in_x[j], adv + 1 + j});
        exp_rows = in_block ? ((exp_rows < MAXR) ? exp_rows + 1 : exp_rows) : 1;
        in_block = !row.in_last;
        if (row.in_last) begin
          drain_pending = 1'b1;
          done_due      = adv + N;
        end
      end
      if (!stall) adv++;
    end
  end

  function automatic row_t splat(input int base, input int step);
    row_t r;
    for (int j = 0; j < N; j++) r[j] = DATA_W'(base + step * j);
    return r;
  endfunction

  task automatic cyc(input bit v, input bit l, input bit s, input bit r, input row_t x);
    row.in_valid = v;
    row.in_last  = l;
    stall        = s;
    rst_n        = r;
    row.in_x     = x;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(0, 0, 0, 1, splat(0, 0));
  endtask

  initial begin
    row_t rx;
    row.in_valid = 1'b0;
    row.in_last  = 1'b0;
    row.in_x     = '0;
    stall        = 1'b0;
    rst_n        = 1'b0;
    repeat (2) cyc(0, 0, 0, 0, splat(0, 0));

    cyc(1, 0, 0, 1, splat(1, 1));
    cyc(1, 1, 0, 1, splat(5, 1));
    idle(6);

    cyc(1, 0, 0, 1, splat(1, 1));
    idle(1);
    cyc(1, 1, 0, 1, splat(9, 0));
    idle(6);

    cyc(1, 0, 0, 1, splat(10, 1));
    cyc(1, 0, 1, 1, splat(20, 1));
    cyc(1, 0, 1, 1, splat(20, 1));
    cyc(1, 1, 0, 1, splat(20, 1));
    cyc(0, 0, 0, 1, splat(0, 0));
    cyc(0, 0, 1, 1, splat(0, 0));
    cyc(0, 0, 1, 1, splat(0, 0));
    idle(8);

    cyc(1, 1, 0, 1, splat(7, 0));
    repeat (5) cyc(1, 1, 0, 1, splat(30, 1));
    idle(6);

    for (int i = 0; i < 5; i++) cyc(1, i == 4, 0, 1, splat(50 + i, 2));
    idle(6);
    cyc(1, 1, 0, 1, splat(60, 1));
    idle(6);

    cyc(1, 1, 0, 1, splat(40, 1));
    idle(2);
    cyc(0, 0, 0, 0, splat(0, 0));
    idle(4);

    repeat (3000) begin
      for (int j = 0; j < N; j++) rx[j] = DATA_W'($urandom);
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0,
          $urandom_range(0, 7) == 0, $urandom_range(0, 199) != 0, rx);
    end
    idle(12);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/qr_row_skew_feeder.md
Name: qr_row_skew_feeder

Overview:
- Upstream feeder for the triangular QR systolic array.
- Accepts one full row of N real samples per handshake and skews it diagonally: element j reaches column j's top VLINK x input exactly j cycles after element 0.
- Generates a per-column freeze so bubbles never update stored r in the PE cells.
- Tracks row blocks: after the last row of a block has fully left the skew network, it pulses done.

Parameters:
- N, 4, number of array columns (≥1).
- CNT_W, 16, width of the row counter (optional feature only).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous, active-low reset.
- in_x  in  real[N]  input row; in_x[j] is destined for column j.
- in_valid  in  1  row offered.
- in_last  in  1  offered row is the last of its block; qualified by in_valid.
- in_ready  out  1  feeder can accept a row this cycle.
- stall  in  1  array-side hold; freezes the whole skew network.
- col_x  out  real[N]  skewed sample to the top of column j.
- col_freeze  out  [N-1:0]  1 = no valid sample at column j this cycle.
- done  out  1  one-cycle pulse, block fully drained.
- rows_seen  out  [CNT_W-1:0]  only with FEEDER_ROWCNT_EN.

Behaviour:
- Reset (rst_n=0 sampled at posedge):
  - col_x all 0.0; col_freeze all 1; done 0; in_ready 0 during the reset cycle.
  - FSM to IDLE; all delay stages cleared (x=0.0, valid=0, last=0).
- Accept rule: a row is accepted when in_valid && in_ready at a posedge.
- in_ready = !stall && (state != DRAIN); it is combinational from stall and state.
- Skew network: column j has a j-deep delay line of {x, valid, last}, followed by an output register.
  - On acceptance, in_x[j] enters stage 0 of column j.
  - Column j presents it on col_x[j] exactly j+1 cycles later, with col_freeze[j]=0.
  - Column 0 latency is 1.
- Bubbles: a cycle with no acceptance and no stall shifts in x=0.0 and valid=0, so that column's col_freeze=1 when the bubble arrives. col_x is forced to 0.0 on bubbles.
- Stall: while stall=1, every delay stage and output register holds its value, the FSM holds, and no row is accepted. col_freeze is forced to all-1 during stall, regardless of held valid bits.
- FSM:
  - IDLE → STREAM on the first acceptance.
  - STREAM → DRAIN on acceptance with in_last=1. The drain counter loads N-1.
  - DRAIN decrements the counter each unstalled cycle. At 0 it pulses done in that cycle and returns to IDLE.
  - N=1 special case: the DRAIN counter loads 0, so done pulses the cycle after the last row is accepted.
  - Timing: done is asserted in the same cycle the last row's element N-1 appears on col_x[N-1].
  - A row accepted in IDLE with in_last=1 is a valid one-row block: IDLE → DRAIN directly.
- A new block may be offered the cycle after done; back-to-back blocks are separated by exactly one IDLE cycle with in_ready=1.
- Reset mid-operation: in-flight samples are discarded, no done pulse, state as at reset.
- in_x is sampled only on acceptance; no-accept cycles ignore in_x and in_last.

Optional Feature:
- Macro: FEEDER_ROWCNT_EN.
- Defined:
  - rows_seen counts rows accepted in the current block, saturating at 2^CNT_W-1.
  - The count includes the last row.
  - It holds its final value from done until the first acceptance of the next block, where it restarts at 1.
  - Reset value is 0.
- Undefined: the rows_seen port and its counter are absent; all other behaviour is identical.

Test Plan:
- Skew timing (N=4, no stall): offer rows [1,2,3,4] then [5,6,7,8] with last=1 on consecutive cycles from t0 ->
  - col_x[0]=1 @t0+1, 5 @t0+2.
  - col_x[3]=4 @t0+4, 8 @t0+5.
  - done pulses @t0+5 only; in_ready=0 during DRAIN.
- Bubble insertion: accept row [1,2,3,4], in_valid=0 one cycle, accept [9,9,9,9] last -> each column shows value, freeze=1 with x=0.0, then 9, at column-skewed times.
- Stall: assert stall 2 cycles mid-stream -> col_x held, col_freeze all 1, in_ready=0; after release the sequence resumes and done is delayed by exactly 2 cycles.
- Single-row block: IDLE, accept [7,7,7,7] with last=1 -> done 4 cycles later; next row accepted the cycle after done.
- Reset mid-drain: rst_n=0 one cycle during DRAIN -> col_freeze all 1, col_x all 0.0, no done pulse, in_ready=1 the cycle after reset releases.
- FEEDER_ROWCNT_EN: 5-row block -> rows_seen=5 at done and held; next block's first accept -> 1. Run a CNT_W=2 build with 6 rows -> saturates at 3.
